// File: rtl/f_le_arbiter.sv
// Round-robin arbiter sharing one external f_less_or_equal comparator
// among N_REQ requesters; one op in flight, grant-to-response two cycles.
module f_le_arbiter #(
   parameter int FLEN  = 64,
   parameter int N_REQ = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ-1:0][FLEN-1:0]  req_a,
   input  logic [N_REQ-1:0][FLEN-1:0]  req_b,
   output logic [N_REQ-1:0]            req_ready,
   output logic [N_REQ-1:0]            rsp_valid,
   output logic                        rsp_res,
   output logic                        rsp_err,
   output logic [7:0]                  err_cnt,
   output logic                        busy,
   output logic [FLEN-1:0]             f_le_a,
   output logic [FLEN-1:0]             f_le_b,
   input  logic                        f_le_res,
   input  logic                        f_le_err
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMP,
      ST_RSP
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   win_idx;
   logic            win_found;
   logic            grant;
   logic [IW-1:0]   cap_idx;
   logic [FLEN-1:0] cap_a;
   logic [FLEN-1:0] cap_b;
   logic            res_q;
   logic            err_q;

   // Winner: first valid requester at or above rr_ptr, wrapping
   always_comb begin
      int            j;
      logic [IW-1:0] jj;
      win_found = 1'b0;
      win_idx   = '0;
      j         = 0;
      jj        = '0;
      for (int i = 0; i < N_REQ; i++) begin
         j = int'(rr_ptr) + i;
         if (j >= N_REQ)
            j = j - N_REQ;
         jj = IW'(j);
         if (!win_found && req_valid[jj]) begin
            win_found = 1'b1;
            win_idx   = jj;
         end
      end
   end

   // Next state and grant; a grant is possible in IDLE and RSP
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      grant     = 1'b0;
      unique case (state)
         ST_IDLE, ST_RSP: begin
            if (!rst && win_found) begin
               grant              = 1'b1;
               req_ready[win_idx] = 1'b1;
               state_nxt          = ST_CMP;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_CMP:  state_nxt = ST_RSP;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Capture winner operands and advance the round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr  <= '0;
         cap_idx <= '0;
         cap_a   <= '0;
         cap_b   <= '0;
      end else if (grant) begin
         cap_a   <= req_a[win_idx];
         cap_b   <= req_b[win_idx];
         cap_idx <= win_idx;
         if (win_idx == IW'(N_REQ - 1))
            rr_ptr <= '0;
         else
            rr_ptr <= win_idx + IW'(1);
      end
   end

   // Register comparator outcome; an error forces the result low
   always_ff @(posedge clk) begin
      if (rst) begin
         res_q <= 1'b0;
         err_q <= 1'b0;
      end else if (state == ST_CMP) begin
         res_q <= f_le_res & ~f_le_err;
         err_q <= f_le_err;
      end
   end

   // Saturating count of responses that carried an error
   always_ff @(posedge clk) begin
      if (rst)
         err_cnt <= '0;
      else if (state == ST_RSP && err_q && err_cnt != 8'hFF)
         err_cnt <= err_cnt + 8'd1;
   end

   // Comparator operands and response bus, zero outside their states
   always_comb begin
      f_le_a    = '0;
      f_le_b    = '0;
      rsp_valid = '0;
      rsp_res   = 1'b0;
      rsp_err   = 1'b0;
      if (state == ST_CMP) begin
         f_le_a = cap_a;
         f_le_b = cap_b;
      end
      if (state == ST_RSP && !rst) begin
         rsp_valid[cap_idx] = 1'b1;
         rsp_res            = res_q;
         rsp_err            = err_q;
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_f_le_arbiter.sv
// Directed bench for f_le_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever rsp_valid is seen.
module tb_f_le_arbiter;

   localparam int FLEN  = 64;
   localparam int N_REQ = 4;

   localparam logic [63:0] ONE = 64'h3FF0000000000000;
   localparam logic [63:0] TWO = 64'h4000000000000000;
   localparam logic [63:0] NAN = 64'h7FF8000000000000;

   logic                       clk;
   logic                       rst;
   logic [N_REQ-1:0]           req_valid;
   logic [N_REQ-1:0][FLEN-1:0] req_a;
   logic [N_REQ-1:0][FLEN-1:0] req_b;
   logic [N_REQ-1:0]           req_ready;
   logic [N_REQ-1:0]           rsp_valid;
   logic                       rsp_res;
   logic                       rsp_err;
   logic [7:0]                 err_cnt;
   logic                       busy;
   logic [FLEN-1:0]            f_le_a;
   logic [FLEN-1:0]            f_le_b;
   logic                       f_le_res;
   logic                       f_le_err;

   typedef struct {
      int idx;
      bit res;
      bit err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   f_le_arbiter #(.FLEN(FLEN), .N_REQ(N_REQ)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_a    (req_a),
      .req_b    (req_b),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid),
      .rsp_res  (rsp_res),
      .rsp_err  (rsp_err),
      .err_cnt  (err_cnt),
      .busy     (busy),
      .f_le_a   (f_le_a),
      .f_le_b   (f_le_b),
      .f_le_res (f_le_res),
      .f_le_err (f_le_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference comparator: NaN operand gives error, else IEEE a <= b
   always_comb begin
      logic nan_a;
      logic nan_b;
      nan_a    = (f_le_a[62:52] == 11'h7FF) && (f_le_a[51:0] != '0);
      nan_b    = (f_le_b[62:52] == 11'h7FF) && (f_le_b[51:0] != '0);
      f_le_err = nan_a | nan_b;
      f_le_res = !f_le_err &&
                 ($bitstoreal(f_le_a) <= $bitstoreal(f_le_b));
   end

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int idx, input bit res, input bit err);
      exp_t e;
      e.idx = idx;
      e.res = res;
      e.err = err;
      exp_q.push_back(e);
   endtask

   task automatic set_all(input logic [63:0] a, input logic [63:0] b);
      for (int i = 0; i < N_REQ; i++) begin
         req_a[i] = a;
         req_b[i] = b;
      end
   endtask

   // Monitor: every response must match the oldest expected one
   always @(negedge clk) begin
      if (rsp_valid != '0) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp got rsp_valid %b expected none",
                     rsp_valid);
         end else begin
            exp_t e;
            logic [N_REQ-1:0] ev;
            e  = exp_q.pop_front();
            ev = '0;
            ev[e.idx] = 1'b1;
            chk("rsp_valid", 64'(rsp_valid), 64'(ev));
            chk("rsp_res", 64'(rsp_res), 64'(e.res));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      set_all(ONE, TWO);

      // Reset: grant suppressed while rst is high
      cyc();
      req_valid = 4'b1111;
      @(negedge clk);
      chk("rst_ready", 64'(req_ready), 64'h0);
      cyc();
      rst       = 1'b0;
      req_valid = '0;
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_err_cnt", 64'(err_cnt), 64'h0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("rst_f_le_a", f_le_a, 64'h0);

      // Single op: 1.0 <= 2.0 from requester 0
      cyc();
      req_valid = 4'b0001;
      push(0, 1'b1, 1'b0);
      @(negedge clk);
      chk("single_ready", 64'(req_ready), 64'h1);
      chk("single_busy_t0", 64'(busy), 64'h0);
      cyc();
      req_valid = '0;
      @(negedge clk);
      chk("single_f_le_a", f_le_a, ONE);
      chk("single_f_le_b", f_le_b, TWO);
      chk("single_busy_t1", 64'(busy), 64'h1);
      chk("single_ready_cmp", 64'(req_ready), 64'h0);
      cyc();
      @(negedge clk);
      chk("single_f_le_a_rsp", f_le_a, 64'h0);
      cyc();
      @(negedge clk);
      chk("single_busy_end", 64'(busy), 64'h0);

      // Round-robin from a fresh pointer, all requesters held valid
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      set_all(ONE, ONE);
      req_valid = 4'b1111;
      for (int k = 0; k <= 8; k++) begin
         logic [N_REQ-1:0] g;
         g = '0;
         if (k % 2 == 0) begin
            g[(k / 2) % 4] = 1'b1;
            push((k / 2) % 4, 1'b1, 1'b0);
         end
         @(negedge clk);
         chk($sformatf("rr_ready_c%0d", k), 64'(req_ready), 64'(g));
         if (k >= 1)
            chk($sformatf("rr_busy_c%0d", k), 64'(busy), 64'h1);
         if (k == 2)
            chk("rr_overlap_rsp0", 64'(rsp_valid), 64'h1);
         cyc();
      end
      req_valid = '0;
      cyc();
      cyc();
      @(negedge clk);
      chk("rr_busy_end", 64'(busy), 64'h0);

      // Error op: NaN operand
      cyc();
      set_all(NAN, ONE);
      req_valid = 4'b0001;
      push(0, 1'b0, 1'b1);
      @(negedge clk);
      chk("err_ready", 64'(req_ready), 64'h1);
      cyc();
      req_valid = '0;
      @(negedge clk);
      chk("err_cnt_before", 64'(err_cnt), 64'h0);
      cyc();
      cyc();
      @(negedge clk);
      chk("err_cnt_one", 64'(err_cnt), 64'h1);

      // 300 more error ops back to back: count saturates at 255
      req_valid = 4'b0001;
      for (int i = 0; i < 300; i++) begin
         push(0, 1'b0, 1'b1);
         cyc();
         if (i == 299)
            req_valid = '0;
         cyc();
      end
      cyc();
      @(negedge clk);
      chk("err_cnt_sat", 64'(err_cnt), 64'd255);

      // Reset mid-op: response discarded, pointer back to 0
      cyc();
      set_all(ONE, TWO);
      req_valid = 4'b0100;
      @(negedge clk);
      chk("rmid_ready", 64'(req_ready), 64'h4);
      cyc();
      req_valid = '0;
      rst       = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("rmid_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("rmid_busy", 64'(busy), 64'h0);
      chk("rmid_err_cnt", 64'(err_cnt), 64'h0);
      cyc();
      req_valid = 4'b1100;
      push(2, 1'b1, 1'b0);
      @(negedge clk);
      chk("rmid_regrant", 64'(req_ready), 64'h4);
      cyc();
      req_valid = '0;
      cyc();
      cyc();

      // Withdrawal: requester 3 drops before it is granted
      rst = 1'b1;
      cyc();
      rst       = 1'b0;
      req_valid = 4'b1001;
      push(0, 1'b1, 1'b0);
      @(negedge clk);
      chk("wd_ready", 64'(req_ready), 64'h1);
      cyc();
      req_valid = 4'b1000;
      cyc();
      req_valid = '0;
      @(negedge clk);
      chk("wd_ready_rsp", 64'(req_ready), 64'h0);
      cyc();
      @(negedge clk);
      chk("wd_busy", 64'(busy), 64'h0);
      cyc();
      cyc();
      @(negedge clk);
      chk("wd_idle_rsp", 64'(rsp_valid), 64'h0);
      chk("queue_drained", 64'(exp_q.size()), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
